// File: rtl/alu_nibble_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: opcodes, FSM states, slice width.
// Imported by the sequencer and available to anything integrating it with the 4-bit ALU.
package alu_nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Counter width that can hold every value 0..n, including the one-past-last step.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// Multi-cycle sequencer: feeds an external 4-bit ALU one nibble per cycle (LSB first),
// chains its carry, and assembles the full-width result behind a valid/ready handshake.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
  input  logic [1:0]                    in_op,
  input  logic                          in_cin,
  output logic [NIBBLE_W-1:0]           alu_a,
  output logic [NIBBLE_W-1:0]           alu_b,
  output logic [1:0]                    alu_op,
  output logic                          alu_cin,
  input  logic [NIBBLE_W-1:0]           alu_res,
  input  logic                          alu_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   out_res,
  output logic                          out_cout,
  output logic                          out_err
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [1:0]       op_q;
  logic             cin_q;
  logic             carry_q;
  logic [W-1:0]     res_q;
  logic             cout_q;
  logic             err_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_res   = res_q;
  assign out_cout  = cout_q;
  assign out_err   = err_q;

  // ALU drive is purely combinational from registered state; idle cycles present all zeros.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_AND;
    alu_cin = 1'b0;
    if (state_q == EXEC) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          alu_a = a_q[i*NIBBLE_W +: NIBBLE_W];
          alu_b = b_q[i*NIBBLE_W +: NIBBLE_W];
        end
      end
      alu_op = op_q;
      if (op_q == OP_ADD) begin
        alu_cin = (idx_q == '0) ? cin_q : carry_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and result registers are reset too, so outputs are defined straight out of reset.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            cin_q <= in_cin;
            res_q <= '0;
            if (in_op == OP_ILL) begin
              // Illegal request skips the ALU entirely and reports straight away.
              state_q <= DONE;
              cout_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= EXEC;
              idx_q   <= '0;
            end
          end
        end

        EXEC: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
              res_q[i*NIBBLE_W +: NIBBLE_W] <= alu_res;
            end
          end
          carry_q <= alu_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            cout_q  <= (op_q == OP_ADD) ? alu_cout : 1'b0;
            err_q   <= 1'b0;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq with an inline behavioural 4-bit ALU on the alu_* ports.
// Expected results come from whole-word arithmetic, independent of the nibble sequencing.
module tb_alu_nibble_seq;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         in_cin = 1'b0;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [1:0]   alu_op;
  logic         alu_cin;
  logic [3:0]   alu_res;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_res;
  logic         out_cout;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cout(out_cout), .out_err(out_err)
  );

  // Stand-in for the existing 4-bit ALU.
  always_comb begin
    case (alu_op)
      2'b00:   {alu_cout, alu_res} = {1'b0, alu_a & alu_b};
      2'b01:   {alu_cout, alu_res} = {1'b0, alu_a | alu_b};
      2'b10:   {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      default: {alu_cout, alu_res} = 5'b0;
    endcase
  end

  // Whole-word reference result.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic cin, output logic [W-1:0] res, output logic cout,
                       output logic err);
    longint sum;
    res = '0; cout = 1'b0; err = 1'b0;
    case (op)
      2'b00: res = a & b;
      2'b01: res = a | b;
      2'b10: begin
        sum  = longint'(a) + longint'(b) + longint'(cin);
        res  = W'(sum);
        cout = sum[W];
      end
      default: err = 1'b1;
    endcase
  endtask

  // Carry entering nibble k of an addition, from the sum of the lower k nibbles.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int k);
    longint mask, sum;
    if (k == 0) return cin;
    mask = (64'd1 << (4 * k)) - 1;
    sum  = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
    return sum[4*k];
  endfunction

  // Issue one request, follow it through EXEC/DONE and the output handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic cin, input int hold, input string tag);
    logic [W-1:0] exp_res;
    logic         exp_cout, exp_err;
    logic [3:0]   exp_na, exp_nb;
    logic         exp_cin;
    int           wait_cnt;
    model(a, b, op, cin, exp_res, exp_cout, exp_err);

    wait_cnt = 0;
    while (in_ready !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_timeout in_ready=%b want 1", tag, in_ready);
    end

    out_ready = (hold == 0);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
    @(negedge clk);
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL %s busy_ready got %b want 0", tag, in_ready);
    end

    if (op != 2'b11) begin
      for (int k = 0; k < N; k++) begin
        exp_na  = 4'((a >> (4 * k)) & 'hF);
        exp_nb  = 4'((b >> (4 * k)) & 'hF);
        exp_cin = (op == 2'b10) ? carry_into(a, b, cin, k) : 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_op, alu_cin, out_valid} !== {exp_na, exp_nb, op, exp_cin, 1'b0}) begin
          errors++;
          $display("FAIL %s exec%0d a=%h b=%h op=%b cin=%b ov=%b want a=%h b=%h op=%b cin=%b ov=0",
                   tag, k, alu_a, alu_b, alu_op, alu_cin, out_valid, exp_na, exp_nb, op, exp_cin);
        end
        @(negedge clk);
      end
    end

    checks++;
    if ({out_valid, out_res, out_cout, out_err} !== {1'b1, exp_res, exp_cout, exp_err}) begin
      errors++;
      $display("FAIL %s result ov=%b res=%h cout=%b err=%b want ov=1 res=%h cout=%b err=%b",
               tag, out_valid, out_res, out_cout, out_err, exp_res, exp_cout, exp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== 11'b0) begin
      errors++; $display("FAIL %s done_alu_idle got a=%h b=%h op=%b cin=%b want 0",
                         tag, alu_a, alu_b, alu_op, alu_cin);
    end

    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 2);
      in_op    = 2'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_res, out_cout, out_err} !== {2'b10, exp_res, exp_cout, exp_err}) begin
        errors++;
        $display("FAIL %s hold%0d ov=%b rdy=%b res=%h cout=%b err=%b want ov=1 rdy=0 res=%h cout=%b err=%b",
                 tag, h, out_valid, in_ready, out_res, out_cout, out_err, exp_res, exp_cout, exp_err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s after_handshake ov=%b rdy=%b want ov=0 rdy=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, alu_a, alu_b, alu_op, alu_cin, out_res, out_cout, out_err} !==
          {1'b1, 1'b0, 11'b0, {W{1'b0}}, 2'b00}) begin
        errors++;
        $display("FAIL reset_idle%0d rdy=%b ov=%b alu_a=%h alu_b=%h alu_op=%b cin=%b res=%h cout=%b err=%b want rdy=1 rest 0",
                 c, in_ready, out_valid, alu_a, alu_b, alu_op, alu_cin, out_res, out_cout, out_err);
      end
    end
  endtask

  task automatic test_add();
    run_op(8'h3C, 8'h4F, 2'b10, 1'b0, 0, "add_3c_4f");
    run_op(8'hFF, 8'h01, 2'b10, 1'b0, 0, "add_wrap");
    run_op(8'h00, 8'h00, 2'b10, 1'b1, 0, "add_cin_only");
  endtask

  task automatic test_logic();
    run_op(8'hA5, 8'h0F, 2'b00, 1'b1, 0, "and_a5_0f");
    run_op(8'hA5, 8'h0F, 2'b01, 1'b1, 0, "or_a5_0f");
  endtask

  task automatic test_illegal();
    run_op(8'hFF, 8'h12, 2'b11, 1'b1, 0, "illegal_op");
    run_op(8'h11, 8'h22, 2'b10, 1'b0, 0, "legal_after_illegal");
  endtask

  task automatic test_backpressure();
    run_op(8'h9E, 8'h73, 2'b10, 1'b1, 6, "backpressure_add");
    run_op(8'h55, 8'hAA, 2'b11, 1'b0, 6, "backpressure_ill");
  endtask

  task automatic test_reset_mid_exec();
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h99; in_op = 2'b10; in_cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_a !== 4'h7 || alu_op !== 2'b10) begin
      errors++; $display("FAIL midreset_setup alu_a=%h alu_op=%b want 7/10", alu_a, alu_op);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, alu_a, alu_b, alu_op, alu_cin} !== {2'b10, 11'b0}) begin
      errors++; $display("FAIL midreset_async rdy=%b ov=%b alu_a=%h alu_op=%b want rdy=1 ov=0 alu 0",
                         in_ready, out_valid, alu_a, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL midreset_quiet%0d ov=%b rdy=%b want ov=0 rdy=1", c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int t = 0; t < 30; t++) begin
      op = 2'($urandom_range(0, 3));
      run_op(W'($urandom), W'($urandom), op, 1'($urandom), int'($urandom_range(0, 4)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
